// File: rtl/ps2_pkg.sv
// Shared PS/2 host transmitter definitions: the transmit FSM state type, the
// odd-parity helper and the default glitch-filter length used by the
// transmitter and the line filter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, XFER, ACK, WAITHI, DONE, ERR
  } ps2_tx_state_t;

  localparam int PS2_FILTER_LEN_DEF = 8;

  // PS/2 frames carry odd parity: the 9 bits {p, byte} hold an odd number of 1s.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronizers on clock and data, a FILTER_LEN
// sample glitch filter on the clock level and a one-cycle falling-edge strobe.
// Ports:
//   clk28, rst_n   system clock, asynchronous active-low reset
//   i_clk, i_dat   raw PS/2 pin levels (asynchronous)
//   o_clk_filt     filtered clock level
//   o_dat_sync     synchronized data level
//   o_clk_fall     one-cycle strobe on a filtered 1->0 clock transition
module ps2_line_filter import ps2_pkg::*; #(
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic i_clk,
  input  logic i_dat,
  output logic o_clk_filt,
  output logic o_dat_sync,
  output logic o_clk_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic [CW-1:0] r_cnt;
  logic          r_filt;
  logic          r_fall;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_cnt      <= '0;
      r_filt     <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], i_clk};
      r_dat_sync <= {r_dat_sync[0], i_dat};
      r_fall     <= 1'b0;
      // r_cnt counts consecutive samples that disagree with the accepted
      // level; any agreeing sample restarts the run.
      if (r_clk_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_cnt  <= '0;
        r_filt <= r_clk_sync[1];
        r_fall <= ~r_clk_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_clk_filt = r_filt;
  assign o_dat_sync = r_dat_sync[1];
  assign o_clk_fall = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// shifts out 8 data bits LSB first plus odd parity on device clock falls,
// releases data for the stop bit, checks the device ack and reports
// tx_done or tx_err. Line outputs are open-drain style (0 = drive low).
// Optional build macro PS2_HOST_TX_RETRY_EN: the first failure of a byte
// re-runs the whole sequence once before reporting tx_err.
// Ports:
//   clk28, rst_n              system clock, asynchronous active-low reset
//   ps2_clk_in, ps2_dat_in    raw pin levels
//   ps2_clk_out, ps2_dat_out  0 = pull line low, 1 = release
//   tx_data, tx_valid, tx_ready  byte handshake (accept when valid & ready)
//   tx_busy                   transfer in progress
//   tx_done, tx_err           one-cycle completion / failure pulses
module ps2_host_tx import ps2_pkg::*; #(
  parameter int CLK_FREQ   = 28_000_000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_MS = 20,
  parameter int FILTER_LEN = PS2_FILTER_LEN_DEF
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_CNT = CLK_FREQ / 1_000_000 * INHIBIT_US;
  localparam int TO_CNT  = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int IW      = $clog2(INH_CNT + 1);
  localparam int TW      = $clog2(TO_CNT + 1);

  ps2_tx_state_t r_state;
  logic [8:0]    r_shift;
  logic [3:0]    r_bitcnt;
  logic [IW-1:0] r_inh;
  logic [TW-1:0] r_to;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [8:0]    r_frame;
  logic          r_retry;
`endif

  logic w_clk_filt, w_dat_sync, w_clk_fall;
  logic w_active, w_fail;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .i_clk      (ps2_clk_in),
    .i_dat      (ps2_dat_in),
    .o_clk_filt (w_clk_filt),
    .o_dat_sync (w_dat_sync),
    .o_clk_fall (w_clk_fall)
  );

  // The timeout window spans from clock release until the bus idles again.
  assign w_active = (r_state == XFER) || (r_state == ACK) || (r_state == WAITHI);
  assign w_fail   = w_active && ((r_to == TW'(TO_CNT - 1)) ||
                    ((r_state == ACK) && w_clk_fall && w_dat_sync));

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      ps2_clk_out <= 1'b1;
      ps2_dat_out <= 1'b1;
      tx_ready    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_inh       <= '0;
      r_to        <= '0;
`ifdef PS2_HOST_TX_RETRY_EN
      r_frame     <= '0;
      r_retry     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (r_state)
        IDLE: begin
`ifdef PS2_HOST_TX_RETRY_EN
          r_retry <= 1'b0;
          if (tx_valid && tx_ready) r_frame <= {odd_parity(tx_data), tx_data};
`endif
          if (tx_valid && tx_ready) begin
            r_shift     <= {odd_parity(tx_data), tx_data};
            r_inh       <= '0;
            ps2_clk_out <= 1'b0;
            tx_busy     <= 1'b1;
            tx_ready    <= 1'b0;
            r_state     <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (r_inh == IW'(INH_CNT - 1)) begin
            ps2_dat_out <= 1'b0;  // start bit
            r_state     <= RTS;
          end else begin
            r_inh <= r_inh + 1'b1;
          end
        end
        RTS: begin
          ps2_clk_out <= 1'b1;
          r_bitcnt    <= '0;
          r_to        <= '0;
          r_state     <= XFER;
        end
        XFER: begin
          if (w_clk_fall) begin
            if (r_bitcnt == 4'd9) begin
              ps2_dat_out <= 1'b1;  // stop bit: release data
              r_state     <= ACK;
            end else begin
              ps2_dat_out <= r_shift[0];
              r_shift     <= {1'b0, r_shift[8:1]};
              r_bitcnt    <= r_bitcnt + 1'b1;
            end
          end
        end
        ACK: begin
          if (w_clk_fall && !w_dat_sync) r_state <= WAITHI;
        end
        WAITHI: begin
          if (w_clk_filt && w_dat_sync) begin
            tx_done <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE, ERR: begin
          tx_busy  <= 1'b0;
          tx_ready <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_active) r_to <= r_to + 1'b1;

      // Failure overrides whatever the state case decided this cycle.
      if (w_fail) begin
        tx_done <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        if (!r_retry) begin
          r_retry     <= 1'b1;
          r_shift     <= r_frame;
          r_inh       <= '0;
          ps2_clk_out <= 1'b0;
          ps2_dat_out <= 1'b1;
          r_state     <= INHIBIT;
        end else begin
          ps2_clk_out <= 1'b1;
          ps2_dat_out <= 1'b1;
          tx_err      <= 1'b1;
          r_state     <= ERR;
        end
`else
        ps2_clk_out <= 1'b1;
        ps2_dat_out <= 1'b1;
        tx_err      <= 1'b1;
        r_state     <= ERR;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model on wired-AND lines.
// Expected frame bits are queued when a byte is offered and popped as the
// device model samples the data line; expected outcomes are queued likewise.
module tb_ps2_host_tx;

  localparam int CLK_FREQ   = 2_000_000;
  localparam int INHIBIT_US = 120;
  localparam int TIMEOUT_MS = 2;
  localparam int FILTER_LEN = 8;
  localparam int INH  = CLK_FREQ / 1_000_000 * INHIBIT_US;  // 240
  localparam int TO   = CLK_FREQ / 1000 * TIMEOUT_MS;       // 4000
  localparam int HALF = CLK_FREQ / 25_000;                  // half period of 12.5 kHz

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic       bfm_clk = 1'b1;
  logic       bfm_dat = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ps2_clk_out, ps2_dat_out, tx_ready, tx_busy, tx_done, tx_err;
  logic       ps2_clk_in, ps2_dat_in;

  int tests = 0, fails = 0;
  int n_done = 0, n_err = 0, base_d = 0, base_e = 0;
  logic sb[$];
  bit   res_q[$];

  assign ps2_clk_in = ps2_clk_out & bfm_clk;
  assign ps2_dat_in = ps2_dat_out & bfm_dat;

  ps2_host_tx #(
    .CLK_FREQ(CLK_FREQ), .INHIBIT_US(INHIBIT_US),
    .TIMEOUT_MS(TIMEOUT_MS), .FILTER_LEN(FILTER_LEN)
  ) dut (
    .clk28(clk28), .rst_n(rst_n),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_out(ps2_clk_out), .ps2_dat_out(ps2_dat_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk28 = ~clk28;

  // Counts high cycles of each pulse, so a stretched pulse counts twice.
  always @(posedge clk28) begin
    if (tx_done) n_done <= n_done + 1;
    if (tx_err)  n_err  <= n_err + 1;
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Device's view of a frame: start, data LSB first, odd parity, stop.
  task automatic push_frame(input logic [7:0] b);
    sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) sb.push_back(b[i]);
    sb.push_back(~^b);
    sb.push_back(1'b1);
  endtask

  task automatic accept(input logic [7:0] b, input bit hold, input bit exp_ok);
    int t;
    res_q.push_back(exp_ok);
    base_d = n_done;
    base_e = n_err;
    tx_data  = b;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 5000) begin @(negedge clk28); t++; end
    check1("accept_wait", t < 5000, 1'b1);
    @(negedge clk28);
    check1("clk_low_1cyc", ps2_clk_out, 1'b0);
    check1("busy_set", tx_busy, 1'b1);
    check1("ready_clr", tx_ready, 1'b0);
    if (!hold) begin
      tx_valid = 1'b0;
      tx_data  = ~b;  // must not disturb the byte in flight
    end
  endtask

  task automatic inhibit(input bit chk);
    int t, lowc, inh;
    t = 0;
    while (ps2_clk_out && t < 1000) begin @(negedge clk28); t++; end
    lowc = 0;
    inh  = 0;
    while (!ps2_clk_out && lowc < 4 * INH) begin
      lowc++;
      if (ps2_dat_out) inh++;
      @(negedge clk28);
    end
    if (chk) begin
      checkn("inhibit_len", inh, INH);
      checkn("clk_low_len", lowc, INH + 1);
    end
    check1("clk_released", ps2_clk_out, 1'b1);
  endtask

  // Device model: samples data at the end of each high phase, then clocks low.
  task automatic bfm(input bit ack_lvl, input bit glitch, input int nclk);
    logic e;
    for (int k = 0; k < nclk; k++) begin
      repeat (HALF) @(negedge clk28);
      if (glitch && k == 4) begin
        bfm_clk = 1'b0;
        repeat (5) @(negedge clk28);
        bfm_clk = 1'b1;
        repeat (HALF) @(negedge clk28);
      end
      check1("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check1($sformatf("frame_bit%0d", k), ps2_dat_in, e);
      end
      if (k == 10 && !ack_lvl) begin
        bfm_dat = 1'b0;
        repeat (4) @(negedge clk28);
      end
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge clk28);
      bfm_clk = 1'b1;
    end
    if (!bfm_dat) begin
      repeat (4) @(negedge clk28);
      bfm_dat = 1'b1;
    end
  endtask

  task automatic finish(input bit linger);
    int t;
    bit exp_ok;
    check1("res_nonempty", res_q.size() != 0, 1'b1);
    exp_ok = (res_q.size() != 0) ? res_q.pop_front() : 1'b0;
    t = 0;
    while (n_done == base_d && n_err == base_e && t < 2000) begin @(negedge clk28); t++; end
    check1("result_seen", t < 2000, 1'b1);
    if (linger) repeat (30) @(negedge clk28);
    checkn("done_pulses", n_done - base_d, int'(exp_ok));
    checkn("err_pulses", n_err - base_e, int'(!exp_ok));
    check1("busy_low", tx_busy, 1'b0);
    check1("ready_high", tx_ready, 1'b1);
    check1("clk_rel", ps2_clk_out, 1'b1);
    check1("dat_rel", ps2_dat_out, 1'b1);
  endtask

  task automatic measure_to(output int t);
    t = 0;
    while (!tx_err && ps2_clk_out && t < TO + 100) begin @(negedge clk28); t++; end
  endtask

  initial begin
    int t;
    logic [7:0] v;
    repeat (3) @(negedge clk28);
    check1("rst_clk_out", ps2_clk_out, 1'b1);
    check1("rst_dat_out", ps2_dat_out, 1'b1);
    check1("rst_ready", tx_ready, 1'b1);
    check1("rst_busy", tx_busy, 1'b0);
    check1("rst_done", tx_done, 1'b0);
    check1("rst_err", tx_err, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk28);

    // Normal transfers, one with a short clock glitch mid-frame.
    push_frame(8'hED); accept(8'hED, 0, 1); inhibit(1); bfm(0, 0, 11); finish(1);
    push_frame(8'h01); accept(8'h01, 0, 1); inhibit(1); bfm(0, 0, 11); finish(1);
    push_frame(8'hFF); accept(8'hFF, 0, 1); inhibit(1); bfm(0, 1, 11); finish(1);

    // Device answers with ack = 1.
`ifdef PS2_HOST_TX_RETRY_EN
    push_frame(8'h5A); accept(8'h5A, 0, 1); inhibit(1); bfm(1, 0, 11);
    push_frame(8'h5A); inhibit(0); bfm(0, 0, 11); finish(1);
`else
    push_frame(8'h5A); accept(8'h5A, 0, 0); inhibit(1); bfm(1, 0, 11); finish(1);
`endif

    // tx_valid held through DONE: the next byte starts straight away.
    push_frame(8'h3C); accept(8'h3C, 1, 1); inhibit(1); bfm(0, 0, 11); finish(0);
    push_frame(8'hC3); accept(8'hC3, 0, 1); inhibit(1); bfm(0, 0, 11); finish(1);

    // Device never clocks: timeout counted from clock release.
    accept(8'h12, 0, 0); inhibit(1);
    measure_to(t);
    checkn("timeout_cycles", t, TO);
`ifdef PS2_HOST_TX_RETRY_EN
    check1("retry_err_quiet", tx_err, 1'b0);
    check1("retry_reinhibit", ps2_clk_out, 1'b0);
    inhibit(0);
    measure_to(t);
    checkn("timeout2_cycles", t, TO);
`endif
    check1("timeout_err", tx_err, 1'b1);
    finish(1);

    // Asynchronous reset while bit 4 is on the line.
    v = 8'hED;
    push_frame(v); accept(v, 0, 0); inhibit(1); bfm(0, 0, 5);
    repeat (20) @(negedge clk28);
    check1("bit4_driven", ps2_dat_out, v[4]);
    #3 rst_n = 1'b0;
    #1;
    check1("arst_clk_rel", ps2_clk_out, 1'b1);
    check1("arst_dat_rel", ps2_dat_out, 1'b1);
    sb.delete();
    res_q.delete();
    @(negedge clk28);
    rst_n = 1'b1;
    repeat (3) @(negedge clk28);
    check1("arst_ready", tx_ready, 1'b1);
    check1("arst_busy", tx_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
